// File: rtl/uart_tx_arbiter_if.sv
// Per-core UART write FIFO head-entry bus: valid/byte/token towards the arbiter, pop strobe back.
interface uart_tx_arbiter_if #(
    parameter int NUM_CPUS = 2,
    parameter int TOK_W    = 3
);
    logic [NUM_CPUS-1:0]            req_valid;
    logic [NUM_CPUS-1:0][7:0]       req_byte;
    logic [NUM_CPUS-1:0][TOK_W-1:0] req_tok;
    logic [NUM_CPUS-1:0]            req_pop;

    modport master (output req_valid, req_byte, req_tok, input  req_pop);
    modport slave  (input  req_valid, req_byte, req_tok, output req_pop);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between per-core write FIFOs, with a
// token-based ownership lock so multi-byte messages from one core stay contiguous.
module uart_tx_arbiter #(
    parameter int NUM_CPUS     = 2,
    parameter int TOK_W        = 3,
    parameter int LOCK_TIMEOUT = 1024,
    localparam int GW          = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1,
    localparam int TW          = $clog2(LOCK_TIMEOUT) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     req,
    input  logic                 o_Tx_Active,
    input  logic                 o_Tx_Done,
    output logic                 i_Tx_DV,
    output logic [7:0]           i_Tx_Byte,
    output logic [GW-1:0]        grant_id,
    output logic                 locked,
    output logic                 lock_timeout,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    state_t              state;
    logic [GW-1:0]       rr_ptr;
    logic [GW-1:0]       owner;
    logic [TOK_W-1:0]    tok_r;
    logic [TW-1:0]       timer;

    logic [NUM_CPUS-1:0] owner_mask;
    logic [NUM_CPUS-1:0] eligible;
    logic [GW-1:0]       sel_idx;
    logic                sel_found;
    logic                owner_idle;
    logic                fire;
    logic                grant;

    function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
        return (int'(g) == NUM_CPUS - 1) ? '0 : g + GW'(1);
    endfunction

    assign owner_mask = NUM_CPUS'(1) << owner;
    assign eligible   = locked ? (req.req_valid & owner_mask) : req.req_valid;
    assign owner_idle = locked && ((req.req_valid & owner_mask) == '0);
    assign fire       = (state == IDLE) && owner_idle && (timer == TW'(LOCK_TIMEOUT - 1));
    // Forced release wins over a coincident request; that request is taken next cycle.
    assign grant      = !rst && (state == IDLE) && sel_found && !o_Tx_Active && !fire;
    assign busy       = (state != IDLE);

    // First eligible core at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CPUS;
            if (!sel_found && eligible[idx]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        req.req_pop = '0;
        if (grant) req.req_pop = NUM_CPUS'(1) << sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            i_Tx_DV      <= 1'b0;
            i_Tx_Byte    <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            lock_timeout <= 1'b0;
            rr_ptr       <= '0;
            owner        <= '0;
            tok_r        <= '0;
            timer        <= '0;
        end else begin
            lock_timeout <= 1'b0;

            // Idle-owner watchdog; holds its count while a byte is in flight.
            if (state == IDLE && owner_idle) begin
                if (fire) begin
                    locked       <= 1'b0;
                    rr_ptr       <= next_ptr(owner);
                    lock_timeout <= 1'b1;
                    timer        <= '0;
                end else if (timer != '1) begin
                    timer <= timer + TW'(1);
                end
            end else if (!owner_idle) begin
                timer <= '0;
            end

            case (state)
                IDLE: begin
                    if (grant) begin
                        i_Tx_Byte <= req.req_byte[sel_idx];
                        tok_r     <= req.req_tok[sel_idx];
                        grant_id  <= sel_idx;
                        i_Tx_DV   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    i_Tx_DV <= 1'b0;
                    state   <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (o_Tx_Done) begin
                        state <= IDLE;
                        if (tok_r != '0) begin
                            locked <= 1'b1;
                            owner  <= grant_id;
                        end else begin
                            locked <= 1'b0;
                            rr_ptr <= next_ptr(grant_id);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
